// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg
//   Definitions shared by the PWM light generator and the PWM duty decoder.
//
//   LEVEL_W           width of a brightness level (levels 0..4)
//   LVL_0 .. LVL_4    brightness level constants, shared with the
//                     generator's comparator and output mux
//   ST_IDLE/MEASURE   duty decoder FSM encoding (also visible on o_state)
//   level_from_hits() turns the four threshold hits into a level 0..4
// ---------------------------------------------------------------------------
package pwm_pkg;

  localparam int LEVEL_W = 3;

  localparam logic [LEVEL_W-1:0] LVL_0 = 3'd0;
  localparam logic [LEVEL_W-1:0] LVL_1 = 3'd1;
  localparam logic [LEVEL_W-1:0] LVL_2 = 3'd2;
  localparam logic [LEVEL_W-1:0] LVL_3 = 3'd3;
  localparam logic [LEVEL_W-1:0] LVL_4 = 3'd4;

  // Decoder FSM encoding.
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_MEASURE = 1'b1;

  // hits[i] is set when the duty cycle reaches the (2i+1)/8 threshold.
  // The thresholds are monotonic, so the level is simply the hit count.
  function automatic logic [LEVEL_W-1:0] level_from_hits(input logic [3:0] hits);
    logic [LEVEL_W-1:0] n;
    n = LVL_0;
    for (int i = 0; i < 4; i++) begin
      if (hits[i]) n = n + LEVEL_W'(1);
    end
    return n;
  endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// ---------------------------------------------------------------------------
// pwm_edge_sync
//   Brings the asynchronous PWM input into the i_clk domain and detects its
//   rising edges.
//
//   Optional build macro: PWM_DEC_FILTER_EN
//     defined   - a glitch filter follows the synchronizer; the filtered
//                 level changes only after FILTER_LEN consecutive equal
//                 synchronized samples that differ from it. Edges are
//                 delayed by FILTER_LEN cycles, high time and period of a
//                 clean waveform are unchanged.
//     undefined - o_s is the synchronizer output directly.
//
//   Ports
//     i_clk    in   system clock
//     i_reset  in   asynchronous active-low reset
//     i_pwm    in   asynchronous PWM input
//     o_s      out  synchronized (optionally filtered) PWM level
//     o_r      out  one-cycle rising-edge strobe of o_s
// ---------------------------------------------------------------------------
module pwm_edge_sync #(
  parameter int FILTER_LEN = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_pwm,
  output logic o_s,
  output logic o_r
);

  if (FILTER_LEN < 1) begin : g_filter_len_check
    $error("pwm_edge_sync: FILTER_LEN must be at least 1");
  end

  logic sync1;
  logic sync2;
  logic s_d;

  // Two-flop synchronizer.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= i_pwm;
      sync2 <= sync1;
    end
  end

`ifdef PWM_DEC_FILTER_EN
  localparam int FCNT_W = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);

  logic [FCNT_W-1:0] flt_cnt;
  logic              s_flt;

  // flt_cnt counts consecutive samples that disagree with s_flt; any
  // agreeing sample restarts the count, so short pulses never get through.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      flt_cnt <= '0;
      s_flt   <= 1'b0;
    end else if (sync2 == s_flt) begin
      flt_cnt <= '0;
    end else if (flt_cnt == FCNT_W'(FILTER_LEN - 1)) begin
      flt_cnt <= '0;
      s_flt   <= sync2;
    end else begin
      flt_cnt <= flt_cnt + FCNT_W'(1);
    end
  end

  assign o_s = s_flt;
`else
  assign o_s = sync2;
`endif

  // Previous level for the edge detector.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      s_d <= 1'b0;
    end else begin
      s_d <= o_s;
    end
  end

  assign o_r = o_s & ~s_d;

endmodule

// File: rtl/pwm_duty_decoder.sv
// ---------------------------------------------------------------------------
// pwm_duty_decoder
//   Measures period and high time of an external PWM waveform in i_clk
//   cycles and quantizes the duty cycle into brightness levels 0..4, the
//   same levels the PWM light generator produces. A measurement is
//   reported once per PWM period; a stuck or absent input is reported as a
//   timeout.
//
//   Optional build macro: PWM_DEC_FILTER_EN (glitch filter in
//   pwm_edge_sync, FILTER_LEN consecutive equal samples).
//
//   Parameters
//     CNT_W       counter width; longest measurable period is 2^CNT_W-2
//     FILTER_LEN  glitch filter length, only used with PWM_DEC_FILTER_EN
//
//   Ports
//     i_clk      in   system clock
//     i_reset    in   asynchronous active-low reset
//     i_pwm      in   asynchronous PWM input
//     o_valid    out  one-cycle pulse when the outputs below update
//     o_period   out  last measured period in cycles
//     o_high     out  last measured high time in cycles
//     o_level    out  quantized brightness 0..4
//     o_timeout  out  no rising edge for 2^CNT_W-1 cycles
//     o_state    out  FSM state (ST_IDLE / ST_MEASURE) for observation
//
//   Output handshake: o_valid is a push-only strobe with no ready. It is
//   high for exactly one cycle whenever o_period/o_high/o_level/o_timeout
//   take new values; those outputs hold until the next o_valid.
// ---------------------------------------------------------------------------
module pwm_duty_decoder
  import pwm_pkg::*;
#(
  parameter int CNT_W      = 10,
  parameter int FILTER_LEN = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_pwm,
  output logic               o_valid,
  output logic [CNT_W-1:0]   o_period,
  output logic [CNT_W-1:0]   o_high,
  output logic [LEVEL_W-1:0] o_level,
  output logic               o_timeout,
  output logic [0:0]         o_state
);

  localparam int               EXT_W   = CNT_W + 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             s;
  logic             r;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] high_cnt;
  logic [0:0]       state;
  logic             timeout_evt;

  // -------------------------------------------------------------------------
  // Synchronizer, optional glitch filter and rising-edge detect.
  // -------------------------------------------------------------------------
  pwm_edge_sync #(
    .FILTER_LEN (FILTER_LEN)
  ) u_edge_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_pwm   (i_pwm),
    .o_s     (s),
    .o_r     (r)
  );

  // -------------------------------------------------------------------------
  // Period and high-time counters. A rising edge restarts both at 1 since
  // the edge cycle itself is the first (high) cycle of the new period.
  // Both saturate so a dead input cannot wrap and fake a short period.
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      period_cnt <= '0;
      high_cnt   <= '0;
    end else if (r) begin
      period_cnt <= CNT_ONE;
      high_cnt   <= CNT_ONE;
    end else begin
      if (period_cnt != CNT_MAX) begin
        period_cnt <= period_cnt + CNT_ONE;
      end
      if (s && (high_cnt != CNT_MAX)) begin
        high_cnt <= high_cnt + CNT_ONE;
      end
    end
  end

  // The timeout fires on the cycle period_cnt steps onto CNT_MAX. Once
  // saturated the counter no longer moves, so the event cannot repeat.
  // A simultaneous rising edge restarts the counter and wins.
  assign timeout_evt = ~r && (period_cnt == (CNT_MAX - CNT_ONE));

  // -------------------------------------------------------------------------
  // Duty quantizer on the pre-update counters (the snapshot taken on r).
  // 8h is compared against p, 3p, 5p and 7p at CNT_W+3 bits, which is wide
  // enough for 7 * (2^CNT_W-1) without overflow.
  // -------------------------------------------------------------------------
  logic [EXT_W-1:0]   h_x8;
  logic [EXT_W-1:0]   p_x1;
  logic [EXT_W-1:0]   p_x3;
  logic [EXT_W-1:0]   p_x5;
  logic [EXT_W-1:0]   p_x7;
  logic [3:0]         hits;
  logic [LEVEL_W-1:0] meas_level;

  always_comb begin
    h_x8 = {high_cnt, 3'b000};
    p_x1 = {3'b000, period_cnt};
    p_x3 = p_x1 + (p_x1 << 1);
    p_x5 = p_x1 + (p_x1 << 2);
    p_x7 = (p_x1 << 3) - p_x1;
    hits = {h_x8 >= p_x7, h_x8 >= p_x5, h_x8 >= p_x3, h_x8 >= p_x1};
    meas_level = level_from_hits(hits);
  end

  // -------------------------------------------------------------------------
  // FSM and registered outputs.
  //   IDLE    + r       -> MEASURE, no report (first period is incomplete)
  //   MEASURE + r       -> MEASURE, report the completed period
  //   any     + timeout -> IDLE, report the stuck level
  // Outputs are loaded on the edge that ends the edge-detect cycle, so
  // o_valid is high in the following cycle.
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state     <= ST_IDLE;
      o_valid   <= 1'b0;
      o_period  <= '0;
      o_high    <= '0;
      o_level   <= LVL_0;
      o_timeout <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (r) begin
        state <= ST_MEASURE;
        if (state == ST_MEASURE) begin
          o_valid   <= 1'b1;
          o_period  <= period_cnt;
          o_high    <= high_cnt;
          o_level   <= meas_level;
          o_timeout <= 1'b0;
        end
      end else if (timeout_evt) begin
        // A stuck-high input reads as full brightness, stuck-low as off.
        state     <= ST_IDLE;
        o_valid   <= 1'b1;
        o_timeout <= 1'b1;
        o_period  <= CNT_MAX;
        o_high    <= s ? CNT_MAX : '0;
        o_level   <= s ? LVL_4 : LVL_0;
      end
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// ---------------------------------------------------------------------------
// tb_pwm_duty_decoder
//   Directed bench for pwm_duty_decoder. Expected reports are pushed into
//   exp_q before the stimulus that produces them; a monitor pops and
//   compares on every o_valid.
// ---------------------------------------------------------------------------
module tb_pwm_duty_decoder;

  localparam int CNT_W      = 10;
  localparam int FILTER_LEN = 4;
  localparam int W          = 2 * CNT_W + 4;
  localparam int MAXC       = (1 << CNT_W) - 1;

`ifdef PWM_DEC_FILTER_EN
  // High and low phases must be at least FILTER_LEN cycles to survive.
  localparam int BP = 20;
  localparam int BH = 6;    // 48>=20, 48<60 -> level 1
  localparam int SP = 20;
  int sweep_h[3] = '{4, 8, 14};
`else
  localparam int BP = 10;
  localparam int BH = 3;    // 24>=10, 24<30 -> level 1
  localparam int SP = 10;
  int sweep_h[3] = '{2, 4, 7};
`endif
  int sweep_l[3] = '{1, 2, 3};

  // -------------------------------------------------------------------------
  // Clock / reset / DUT
  // -------------------------------------------------------------------------
  logic             i_clk   = 1'b0;
  logic             i_reset = 1'b0;
  logic             i_pwm   = 1'b0;
  logic             o_valid;
  logic [CNT_W-1:0] o_period;
  logic [CNT_W-1:0] o_high;
  logic [2:0]       o_level;
  logic             o_timeout;
  logic [0:0]       o_state;

  always #5 i_clk = ~i_clk;

  pwm_duty_decoder #(
    .CNT_W      (CNT_W),
    .FILTER_LEN (FILTER_LEN)
  ) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_pwm     (i_pwm),
    .o_valid   (o_valid),
    .o_period  (o_period),
    .o_high    (o_high),
    .o_level   (o_level),
    .o_timeout (o_timeout),
    .o_state   (o_state)
  );

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int           vectors     = 0;
  int           miscompares = 0;
  logic [W-1:0] mon_exp;
  logic [W-1:0] mon_act;

  function automatic logic [W-1:0] pack(input int p, input int h, input int l, input bit t);
    return {CNT_W'(p), CNT_W'(h), 3'(l), t};
  endfunction

  task automatic push(input int p, input int h, input int l, input bit t);
    exp_q.push_back(pack(p, h, l, t));
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every o_valid must match the oldest expected report.
  always @(negedge i_clk) begin
    if (o_valid === 1'b1) begin
      vectors++;
      mon_act = {o_period, o_high, o_level, o_timeout};
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_valid: got period=%0d high=%0d level=%0d timeout=%0d, required no pulse",
                 o_period, o_high, o_level, o_timeout);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          miscompares++;
          $display("FAIL report: got period=%0d high=%0d level=%0d timeout=%0d, required period=%0d high=%0d level=%0d timeout=%0d",
                   o_period, o_high, o_level, o_timeout,
                   mon_exp[W-1 -: CNT_W], mon_exp[W-1-CNT_W -: CNT_W], mon_exp[3:1], mon_exp[0]);
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  // Hold i_pwm at v for n clock cycles, changing it away from the edge.
  task automatic drive(input bit v, input int n);
    repeat (n) begin
      @(posedge i_clk);
      #2 i_pwm = v;
    end
  endtask

  task automatic pwm_periods(input int p, input int h, input int n);
    repeat (n) begin
      if (h > 0) drive(1'b1, h);
      drive(1'b0, p - h);
    end
  endtask

  // One more rising edge to complete the last period, then stay high.
  task automatic close_edge();
    drive(1'b1, 16);
  endtask

  // Wait (bounded) until every expected report has been seen.
  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      @(posedge i_clk);
      k++;
    end
    @(negedge i_clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_missing: got %0d reports still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    @(posedge i_clk);
    #3 i_reset = 1'b0;
    i_pwm = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b1;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({o_valid, o_state, o_period, o_high, o_level, o_timeout});
  endfunction

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    // Reset held with i_pwm low, then released.
    i_reset = 1'b0;
    i_pwm   = 1'b0;
    repeat (3) @(negedge i_clk);
    check("reset_hold_outputs", all_outs(), 32'd0);
    i_reset = 1'b1;
    repeat (20) @(negedge i_clk);
    check("idle_after_reset", all_outs(), 32'd0);

    // Base waveform: first edge silent, then one report per edge.
    for (int i = 0; i < 4; i++) push(BP, BH, 1, 1'b0);
    pwm_periods(BP, BH, 4);
    close_edge();
    drain("base_period");
    check("state_measure", 32'(o_state), 32'd1);
    do_reset();

    // Duty sweep through the measured levels 1..3.
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < 3; i++) push(SP, sweep_h[j], sweep_l[j], 1'b0);
      pwm_periods(SP, sweep_h[j], 3);
      close_edge();
      drain("sweep");
      do_reset();
    end

    // 0% duty: constant low, reported through the timeout as level 0.
    push(MAXC, 0, 0, 1'b1);
    drive(1'b0, 1040);
    drain("const_low");
    check("const_low_state_idle", 32'(o_state), 32'd0);
    do_reset();

    // 100% duty: constant high, timeout with full high time and level 4.
    push(MAXC, MAXC, 4, 1'b1);
    drive(1'b1, 1060);
    drain("const_high");
    do_reset();

    // Stuck low after valid periods: exactly one timeout report.
    push(BP, BH, 1, 1'b0);
    push(BP, BH, 1, 1'b0);
    push(MAXC, 0, 0, 1'b1);
    pwm_periods(BP, BH, 3);
    drive(1'b0, 1100);
    drain("stuck_low");
    check("timeout_held", 32'(o_timeout), 32'd1);
    // Restart: first edge silent, the next edges clear the timeout.
    push(BP, BH, 1, 1'b0);
    push(BP, BH, 1, 1'b0);
    pwm_periods(BP, BH, 2);
    close_edge();
    drain("restart");
    check("timeout_cleared", 32'(o_timeout), 32'd0);
    do_reset();

    // Asynchronous reset mid-period.
    push(BP, BH, 1, 1'b0);
    pwm_periods(BP, BH, 2);
    drain("pre_reset");
    check("pre_reset_period", 32'(o_period), 32'(BP));
    @(posedge i_clk);
    #3 i_reset = 1'b0;
    #1 check("async_reset_clear", all_outs(), 32'd0);
    i_pwm = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b1;
    push(BP, BH, 1, 1'b0);
    pwm_periods(BP, BH, 1);
    close_edge();
    drain("post_reset");
    do_reset();

    // 20/5 waveform with a 2-cycle high glitch in the low phase.
`ifdef PWM_DEC_FILTER_EN
    for (int i = 0; i < 3; i++) push(20, 5, 1, 1'b0);
`else
    for (int i = 0; i < 3; i++) begin
      push(10, 5, 2, 1'b0);
      push(10, 2, 1, 1'b0);
    end
`endif
    repeat (3) begin
      drive(1'b1, 5);
      drive(1'b0, 5);
      drive(1'b1, 2);
      drive(1'b0, 8);
    end
    close_edge();
    drain("glitch");
    do_reset();

    repeat (5) @(negedge i_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute bound on the run.
  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, required finish within 500000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
